seg_scan_decoder: RTL and testbench

//   Receive-side counterpart of the 4-digit multiplexed 7-segment display driver.

---
 rtl/seg_scan_decoder.sv | 154 +++++++++++++++
 tb/tb_seg_scan_decoder.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_decoder.sv
// rtl/seg_scan_decoder.sv - recovers 16-bit hex value and decimal points from a 4-digit 7-segment scan bus
// Optional: SEGDEC_CHANGE_ONLY_EN suppresses valid for frames identical to the last reported one.
module seg_scan_decoder #(
  parameter int STABLE_CYC  = 4,
  parameter int TIMEOUT_CYC = 200000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  AN,
  input  logic [7:0]  SEGMENT,
  output logic [15:0] value,
  output logic [3:0]  dp,
  output logic        valid,
  output logic        bad_seg,
  output logic        stale
);

  localparam int SW = $clog2(STABLE_CYC + 1);
  localparam int IW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [SW-1:0] STAB_LAST = SW'(STABLE_CYC - 1);
  localparam logic [SW-1:0] STAB_SAT  = SW'(STABLE_CYC);
  localparam logic [IW-1:0] IDLE_LAST = IW'(TIMEOUT_CYC - 1);
  localparam logic [IW-1:0] IDLE_SAT  = IW'(TIMEOUT_CYC);

  logic [3:0]    an_s1, an_s2, an_q;
  logic [7:0]    seg_s1, seg_s2, seg_q;
  logic [SW-1:0] stab_cnt;
  logic [IW-1:0] idle_cnt;
  logic [15:0]   stage_val;
  logic [3:0]    stage_dp;
  logic [3:0]    mask;
  logic          ferr;
  logic          same, onehot, accept, complete, timeout_hit, upd;
  logic [1:0]    digit;
  logic [3:0]    sel;
  logic [4:0]    dec;

  function automatic logic [4:0] seg_decode(input logic [6:0] s);
    case (s)
      7'h40: seg_decode = 5'h00;
      7'h79: seg_decode = 5'h01;
      7'h24: seg_decode = 5'h02;
      7'h30: seg_decode = 5'h03;
      7'h19: seg_decode = 5'h04;
      7'h12: seg_decode = 5'h05;
      7'h02: seg_decode = 5'h06;
      7'h78: seg_decode = 5'h07;
      7'h00: seg_decode = 5'h08;
      7'h10: seg_decode = 5'h09;
      7'h08: seg_decode = 5'h0A;
      7'h03: seg_decode = 5'h0B;
      7'h46: seg_decode = 5'h0C;
      7'h21: seg_decode = 5'h0D;
      7'h06: seg_decode = 5'h0E;
      7'h0E: seg_decode = 5'h0F;
      default: seg_decode = 5'h10;  // bit 4 flags an undecodable pattern
    endcase
  endfunction

  always_comb begin
    onehot = 1'b1;
    digit  = 2'd0;
    case (an_s2)
      4'b1110: digit = 2'd0;
      4'b1101: digit = 2'd1;
      4'b1011: digit = 2'd2;
      4'b0111: digit = 2'd3;
      default: onehot = 1'b0;
    endcase
  end

  assign same        = ({an_s2, seg_s2} == {an_q, seg_q});
  // Counter saturates past STAB_LAST so a long stable run accepts only once.
  assign accept      = same && (stab_cnt == STAB_LAST) && onehot;
  assign sel         = 4'b0001 << digit;
  assign dec         = seg_decode(seg_s2[6:0]);
  assign complete    = (mask == 4'hF);
  assign timeout_hit = (idle_cnt == IDLE_LAST) && !accept;
`ifdef SEGDEC_CHANGE_ONLY_EN
  assign upd = ({stage_val, stage_dp, ferr} != {value, dp, bad_seg});
`else
  assign upd = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_s1    <= 4'hF;
      an_s2    <= 4'hF;
      an_q     <= 4'hF;
      seg_s1   <= 8'hFF;
      seg_s2   <= 8'hFF;
      seg_q    <= 8'hFF;
      stab_cnt <= '0;
    end else begin
      an_s1  <= AN;
      an_s2  <= an_s1;
      an_q   <= an_s2;
      seg_s1 <= SEGMENT;
      seg_s2 <= seg_s1;
      seg_q  <= seg_s2;
      if (!same)
        stab_cnt <= '0;
      else if (stab_cnt != STAB_SAT)
        stab_cnt <= stab_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt  <= '0;
      stage_val <= '0;
      stage_dp  <= '0;
      mask      <= '0;
      ferr      <= 1'b0;
      value     <= '0;
      dp        <= '0;
      valid     <= 1'b0;
      bad_seg   <= 1'b0;
      stale     <= 1'b1;
    end else begin
      valid <= 1'b0;
      if (accept)
        idle_cnt <= '0;
      else if (idle_cnt != IDLE_SAT)
        idle_cnt <= idle_cnt + 1'b1;

      if (accept) begin
        stage_val[digit*4 +: 4] <= dec[3:0];
        stage_dp[digit]         <= ~seg_s2[7];
      end

      // An accept landing on the completion cycle seeds the next frame.
      if (complete) begin
        mask  <= accept ? sel : 4'h0;
        ferr  <= accept & dec[4];
        stale <= 1'b0;
        if (upd) begin
          value   <= stage_val;
          dp      <= stage_dp;
          bad_seg <= ferr;
          valid   <= 1'b1;
        end
      end else if (timeout_hit) begin
        mask  <= 4'h0;
        ferr  <= 1'b0;
        stale <= 1'b1;
      end else if (accept) begin
        mask <= mask | sel;
        ferr <= ferr | dec[4];
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// tb/tb_seg_scan_decoder.sv - directed self-checking bench for seg_scan_decoder
module tb_seg_scan_decoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  AN = 4'hF;
  logic [7:0]  SEGMENT = 8'hFF;
  logic [15:0] value;
  logic [3:0]  dp;
  logic        valid, bad_seg, stale;

  int checks = 0;
  int errors = 0;
  int vcnt = 0;

  logic [7:0] seg_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  seg_scan_decoder #(.STABLE_CYC(4), .TIMEOUT_CYC(64)) dut (
    .clk(clk), .rst_n(rst_n), .AN(AN), .SEGMENT(SEGMENT),
    .value(value), .dp(dp), .valid(valid), .bad_seg(bad_seg), .stale(stale)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (valid) vcnt++;

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input int d, input logic [3:0] nib, input logic dpb, input int hold);
    logic [7:0] s;
    s = seg_tab[nib];
    AN = ~(4'b0001 << d);
    SEGMENT = {~dpb, s[6:0]};
    cyc(hold);
  endtask

  task automatic blank(input int n);
    AN = 4'hF;
    SEGMENT = 8'hFF;
    cyc(n);
  endtask

  task automatic scan(input logic [15:0] v, input logic [3:0] d, input int hold);
    for (int i = 0; i < 4; i++) drive(i, v[4*i +: 4], d[i], hold);
    blank(4);
  endtask

  task automatic test_reset;
    cyc(3);
    rst_n = 1'b1;
    cyc(2);
    checks++; if (value !== 16'h0) begin errors++; $display("FAIL reset_value: got %h expected 0000", value); end
    checks++; if (dp !== 4'h0) begin errors++; $display("FAIL reset_dp: got %b expected 0000", dp); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", valid); end
    checks++; if (bad_seg !== 1'b0) begin errors++; $display("FAIL reset_bad_seg: got %b expected 0", bad_seg); end
    checks++; if (stale !== 1'b1) begin errors++; $display("FAIL reset_stale: got %b expected 1", stale); end
  endtask

  task automatic test_basic_scan;
    int v0;
    v0 = vcnt;
    for (int i = 0; i < 3; i++) drive(i, 16'h12AF >> (4*i), 1'b0, 10);
    checks++; if (stale !== 1'b1) begin errors++; $display("FAIL basic_stale_before: got %b expected 1", stale); end
    checks++; if (vcnt - v0 !== 0) begin errors++; $display("FAIL basic_early_valid: got %0d expected 0", vcnt - v0); end
    drive(3, 4'h1, 1'b0, 10);
    blank(4);
    checks++; if (vcnt - v0 !== 1) begin errors++; $display("FAIL basic_valid_cnt1: got %0d expected 1", vcnt - v0); end
    checks++; if (value !== 16'h12AF) begin errors++; $display("FAIL basic_value: got %h expected 12af", value); end
    checks++; if (dp !== 4'h0) begin errors++; $display("FAIL basic_dp: got %b expected 0000", dp); end
    checks++; if (bad_seg !== 1'b0) begin errors++; $display("FAIL basic_bad_seg: got %b expected 0", bad_seg); end
    checks++; if (stale !== 1'b0) begin errors++; $display("FAIL basic_stale_after: got %b expected 0", stale); end
    scan(16'h12AF, 4'h0, 10);
    checks++; if (vcnt - v0 !== 2) begin errors++; $display("FAIL basic_valid_cnt2: got %0d expected 2", vcnt - v0); end
  endtask

  task automatic test_short_hold;
    int v0;
    v0 = vcnt;
    for (int r = 0; r < 8; r++)
      for (int i = 0; i < 4; i++) begin
        drive(i, 4'h8, 1'b0, 3);
        if (r == 1 && i == 3) begin
          checks++; if (stale !== 1'b0) begin errors++; $display("FAIL short_stale_early: got %b expected 0", stale); end
        end
      end
    blank(4);
    checks++; if (vcnt - v0 !== 0) begin errors++; $display("FAIL short_no_valid: got %0d expected 0", vcnt - v0); end
    checks++; if (stale !== 1'b1) begin errors++; $display("FAIL short_stale_late: got %b expected 1", stale); end
  endtask

  task automatic test_bad_seg;
    int v0;
    v0 = vcnt;
    drive(0, 4'h0, 1'b1, 10);
    drive(1, 4'h0, 1'b0, 10);
    AN = 4'b1011;
    SEGMENT = 8'hFF;
    cyc(10);
    drive(3, 4'h0, 1'b0, 10);
    blank(4);
    checks++; if (vcnt - v0 !== 1) begin errors++; $display("FAIL bad_valid_cnt: got %0d expected 1", vcnt - v0); end
    checks++; if (value !== 16'h0000) begin errors++; $display("FAIL bad_value: got %h expected 0000", value); end
    checks++; if (dp !== 4'b0001) begin errors++; $display("FAIL bad_dp: got %b expected 0001", dp); end
    checks++; if (bad_seg !== 1'b1) begin errors++; $display("FAIL bad_flag: got %b expected 1", bad_seg); end
    checks++; if (stale !== 1'b0) begin errors++; $display("FAIL bad_stale: got %b expected 0", stale); end
    scan(16'h0000, 4'h0, 10);
    checks++; if (bad_seg !== 1'b0) begin errors++; $display("FAIL bad_clear: got %b expected 0", bad_seg); end
    checks++; if (dp !== 4'b0000) begin errors++; $display("FAIL bad_dp_clear: got %b expected 0000", dp); end
  endtask

  task automatic test_glitch;
    int v0;
    v0 = vcnt;
    drive(0, 4'h4, 1'b0, 10);
    drive(1, 4'h3, 1'b0, 10);
    AN = 4'b1100;
    SEGMENT = seg_tab[8];
    cyc(20);
    blank(5);
    drive(2, 4'h2, 1'b0, 10);
    blank(5);
    checks++; if (vcnt - v0 !== 0) begin errors++; $display("FAIL glitch_early_valid: got %0d expected 0", vcnt - v0); end
    drive(3, 4'h1, 1'b0, 10);
    blank(4);
    checks++; if (vcnt - v0 !== 1) begin errors++; $display("FAIL glitch_valid_cnt: got %0d expected 1", vcnt - v0); end
    checks++; if (value !== 16'h1234) begin errors++; $display("FAIL glitch_value: got %h expected 1234", value); end
  endtask

  task automatic test_reset_mid_frame;
    int v0;
    drive(0, 4'hD, 1'b0, 10);
    drive(1, 4'hC, 1'b0, 10);
    drive(2, 4'hB, 1'b0, 10);
    rst_n = 1'b0;
    #2;
    checks++; if (value !== 16'h0) begin errors++; $display("FAIL midrst_value: got %h expected 0000", value); end
    checks++; if (stale !== 1'b1) begin errors++; $display("FAIL midrst_stale: got %b expected 1", stale); end
    checks++; if (dp !== 4'h0 || bad_seg !== 1'b0 || valid !== 1'b0) begin
      errors++; $display("FAIL midrst_flags: got dp=%b bad=%b valid=%b expected 0", dp, bad_seg, valid);
    end
    AN = 4'hF;
    SEGMENT = 8'hFF;
    cyc(3);
    rst_n = 1'b1;
    cyc(2);
    v0 = vcnt;
    drive(3, 4'hA, 1'b0, 10);
    blank(10);
    checks++; if (vcnt - v0 !== 0) begin errors++; $display("FAIL midrst_no_carry: got %0d expected 0", vcnt - v0); end
    scan(16'hABCD, 4'h0, 10);
    checks++; if (vcnt - v0 !== 1) begin errors++; $display("FAIL midrst_valid_cnt: got %0d expected 1", vcnt - v0); end
    checks++; if (value !== 16'hABCD) begin errors++; $display("FAIL midrst_value2: got %h expected abcd", value); end
  endtask

  task automatic test_back_to_back;
    int v0, e2, e3;
`ifdef SEGDEC_CHANGE_ONLY_EN
    e2 = 1; e3 = 2;
`else
    e2 = 2; e3 = 3;
`endif
    v0 = vcnt;
    scan(16'h5555, 4'h0, 10);
    scan(16'h5555, 4'h0, 10);
    checks++; if (vcnt - v0 !== e2) begin errors++; $display("FAIL repeat_valid_cnt: got %0d expected %0d", vcnt - v0, e2); end
    checks++; if (value !== 16'h5555) begin errors++; $display("FAIL repeat_value: got %h expected 5555", value); end
    scan(16'h5556, 4'h0, 10);
    checks++; if (vcnt - v0 !== e3) begin errors++; $display("FAIL change_valid_cnt: got %0d expected %0d", vcnt - v0, e3); end
    checks++; if (value !== 16'h5556) begin errors++; $display("FAIL change_value: got %h expected 5556", value); end
  endtask

  initial begin
    test_reset;
    test_basic_scan;
    test_short_hold;
    test_bad_seg;
    test_glitch;
    test_reset_mid_frame;
    test_back_to_back;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
